// File: rtl/mega_mux_stream_if.sv
// mega_mux_stream_if: channel-side and output-side handshake bundle for mega_mux_stream
interface mega_mux_stream_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 5,
  parameter int SEL_W  = 4
);
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_chan;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid, sel_err
  );
  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid, sel_err
  );
endinterface

// File: rtl/mega_mux_stream.sv
// mega_mux_stream: registered handshaked N-way word mux, select or round-robin grant.
// MEGA_MUX_ERR_CNT_EN adds err_cnt, a saturating count of sel_err pulses.
module mega_mux_stream #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 5,
  parameter int SEL_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MEGA_MUX_ERR_CNT_EN
  output logic [7:0]       err_cnt,
`endif
  mega_mux_stream_if.slave bus
);
  localparam int NS = 1 << SEL_W;
  logic [WIDTH-1:0] words [NS];
  logic [NS-1:0]    valid_pad;
  logic             load_en, sel_ok, rr_hit, gnt_vld, xfer;
  logic [SEL_W-1:0] rr_idx, gnt_idx;
  logic [SEL_W:0]   c;
  logic             out_valid_q, out_valid_d, sel_err_q, sel_err_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d, rr_ptr_q, rr_ptr_d;
  // pad to a power of two so sel can index directly; unused slots read as idle
  assign valid_pad = NS'(bus.in_valid);
  for (genvar i = 0; i < NS; i++) begin : g_w
    if (i < NUM_IN) begin : g_in
      assign words[i] = bus.in_data[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign words[i] = '0;
    end
  end
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    c = '0;
    // scan farthest-first so the nearest valid channel after rr_ptr wins
    for (int k = NUM_IN; k >= 1; k--) begin
      c = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
      c = c >= (SEL_W+1)'(NUM_IN) ? c - (SEL_W+1)'(NUM_IN) : c;
      if (valid_pad[c[SEL_W-1:0]]) begin
        rr_hit = 1'b1;
        rr_idx = c[SEL_W-1:0];
      end
    end
    load_en     = !out_valid_q | bus.out_ready;
    sel_ok      = {1'b0, bus.sel} < (SEL_W+1)'(NUM_IN);
    gnt_idx     = bus.mode ? rr_idx : bus.sel;
    gnt_vld     = bus.mode ? rr_hit : sel_ok & valid_pad[bus.sel];
    xfer        = load_en & gnt_vld;
    out_valid_d = load_en ? xfer : out_valid_q;
    out_data_d  = xfer ? words[gnt_idx] : out_data_q;
    out_chan_d  = xfer ? gnt_idx : out_chan_q;
    rr_ptr_d    = xfer & bus.mode ? gnt_idx : rr_ptr_q;
    sel_err_d   = load_en & !bus.mode & !sel_ok;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr_q    <= SEL_W'(NUM_IN - 1);
      sel_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_err_q   <= sel_err_d;
    end
  end
  assign bus.in_ready  = NUM_IN'(xfer) << gnt_idx;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.sel_err   = sel_err_q;
`ifdef MEGA_MUX_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else if (sel_err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end
  assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_mega_mux_stream.sv
// tb_mega_mux_stream: directed self-checking bench for mega_mux_stream
module tb_mega_mux_stream;
  localparam int W = 32, N = 5, S = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  int pass = 0, total = 0;
  mega_mux_stream_if #(.WIDTH(W), .NUM_IN(N), .SEL_W(S)) bus();
`ifdef MEGA_MUX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif
  mega_mux_stream #(.WIDTH(W), .NUM_IN(N), .SEL_W(S)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef MEGA_MUX_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.mode = 1'b0;
    bus.sel = '0;
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = 32'd1 << i;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", bus.out_valid); else pass++;
    total++; if (bus.out_data !== 32'd0) $display("FAIL reset_data got %0h want 0", bus.out_data); else pass++;
    total++; if (bus.out_chan !== 4'd0) $display("FAIL reset_chan got %0d want 0", bus.out_chan); else pass++;
    total++; if (bus.sel_err !== 1'b0) $display("FAIL reset_sel_err got %0b want 0", bus.sel_err); else pass++;
    total++; if (bus.in_ready !== 5'd0) $display("FAIL reset_in_ready got %b want 00000", bus.in_ready); else pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_select();
    do_reset();
    bus.in_valid = 5'h1F;
    for (int s = 0; s < N; s++) begin
      bus.sel = 4'(s);
      #1;
      total++; if (bus.in_ready !== (5'd1 << s)) $display("FAIL sel_in_ready s=%0d got %b want %b", s, bus.in_ready, 5'd1 << s); else pass++;
      tick();
      total++; if (bus.out_data !== (32'd1 << s)) $display("FAIL sel_data s=%0d got %0h want %0h", s, bus.out_data, 32'd1 << s); else pass++;
      total++; if (bus.out_chan !== 4'(s)) $display("FAIL sel_chan got %0d want %0d", bus.out_chan, s); else pass++;
      total++; if (bus.out_valid !== 1'b1) $display("FAIL sel_valid s=%0d got %0b want 1", s, bus.out_valid); else pass++;
    end
  endtask

  task automatic test_sel_err();
    int pulses = 0;
    for (int s = 5; s < 8; s++) begin
      bus.sel = 4'(s);
      #1;
      total++; if (bus.in_ready !== 5'd0) $display("FAIL err_in_ready s=%0d got %b want 00000", s, bus.in_ready); else pass++;
      tick();
      total++; if (bus.out_valid !== 1'b0) $display("FAIL err_valid s=%0d got %0b want 0", s, bus.out_valid); else pass++;
      if (bus.sel_err === 1'b1) pulses++;
    end
    total++; if (pulses != 3) $display("FAIL err_pulses got %0d want 3", pulses); else pass++;
    bus.sel = '0;
    bus.in_valid = '0;
    tick();
    total++; if (bus.sel_err !== 1'b0) $display("FAIL err_clear got %0b want 0", bus.sel_err); else pass++;
`ifdef MEGA_MUX_ERR_CNT_EN
    total++; if (err_cnt !== 8'd3) $display("FAIL err_cnt3 got %0d want 3", err_cnt); else pass++;
`endif
    bus.mode = 1'b1;
    bus.sel = 4'd7;
    tick();
    total++; if (bus.sel_err !== 1'b0) $display("FAIL err_rr_mode got %0b want 0", bus.sel_err); else pass++;
    bus.mode = 1'b0;
    bus.sel = 4'd1;
    bus.in_valid = 5'h1F;
    tick();
    bus.out_ready = 1'b0;
    bus.sel = 4'd7;
    tick();
    total++; if (bus.sel_err !== 1'b0) $display("FAIL err_stall got %0b want 0", bus.sel_err); else pass++;
    total++; if (bus.out_valid !== 1'b1) $display("FAIL err_stall_valid got %0b want 1", bus.out_valid); else pass++;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_a [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [3:0] exp_b [4] = '{4'd2, 4'd4, 4'd2, 4'd4};
    do_reset();
    bus.mode = 1'b1;
    bus.sel = 4'd3;
    bus.in_valid = 5'h1F;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (bus.out_chan !== exp_a[i] || bus.out_valid !== 1'b1) $display("FAIL rr_all i=%0d got chan %0d valid %0b want chan %0d valid 1", i, bus.out_chan, bus.out_valid, exp_a[i]); else pass++;
    end
    bus.in_valid = 5'b10100;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.out_chan !== exp_b[i]) $display("FAIL rr_sparse i=%0d got %0d want %0d", i, bus.out_chan, exp_b[i]); else pass++;
      total++; if (bus.out_data !== (32'd1 << exp_b[i])) $display("FAIL rr_sparse_data i=%0d got %0h want %0h", i, bus.out_data, 32'd1 << exp_b[i]); else pass++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.sel = 4'd1;
    bus.in_valid = 5'h1F;
    tick();
    bus.out_ready = 1'b0;
    bus.sel = 4'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bus.in_ready !== 5'd0) $display("FAIL bp_in_ready i=%0d got %b want 00000", i, bus.in_ready); else pass++;
      tick();
      total++; if (bus.out_data !== 32'd2 || bus.out_chan !== 4'd1 || bus.out_valid !== 1'b1) $display("FAIL bp_hold i=%0d got data %0h chan %0d valid %0b want 2 1 1", i, bus.out_data, bus.out_chan, bus.out_valid); else pass++;
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 5'b00100) $display("FAIL bp_release_ready got %b want 00100", bus.in_ready); else pass++;
    tick();
    total++; if (bus.out_data !== 32'd4 || bus.out_chan !== 4'd2 || bus.out_valid !== 1'b1) $display("FAIL bp_no_bubble got data %0h chan %0d valid %0b want 4 2 1", bus.out_data, bus.out_chan, bus.out_valid); else pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.mode = 1'b1;
    bus.in_valid = 5'h1F;
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0) $display("FAIL async_rst got valid %0b data %0h want 0 0", bus.out_valid, bus.out_data); else pass++;
    #2;
    rst_n = 1'b1;
    tick();
    total++; if (bus.out_chan !== 4'd0 || bus.out_data !== 32'd1) $display("FAIL async_first_grant got chan %0d data %0h want 0 1", bus.out_chan, bus.out_data); else pass++;
    tick();
    total++; if (bus.out_chan !== 4'd1) $display("FAIL async_second_grant got %0d want 1", bus.out_chan); else pass++;
  endtask

`ifdef MEGA_MUX_ERR_CNT_EN
  task automatic test_err_cnt_sat();
    do_reset();
    total++; if (err_cnt !== 8'd0) $display("FAIL cnt_reset got %0d want 0", err_cnt); else pass++;
    bus.sel = 4'd5;
    bus.in_valid = 5'h1F;
    repeat (300) tick();
    bus.sel = '0;
    bus.in_valid = '0;
    tick();
    total++; if (err_cnt !== 8'd255) $display("FAIL cnt_sat got %0d want 255", err_cnt); else pass++;
    repeat (5) tick();
    total++; if (err_cnt !== 8'd255) $display("FAIL cnt_hold got %0d want 255", err_cnt); else pass++;
    rst_n = 1'b0;
    #1;
    total++; if (err_cnt !== 8'd0) $display("FAIL cnt_clear got %0d want 0", err_cnt); else pass++;
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_select();
    test_sel_err();
    test_round_robin();
    test_backpressure();
    test_async_reset();
`ifdef MEGA_MUX_ERR_CNT_EN
    test_err_cnt_sat();
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
